// File: rtl/upscale3x_ctrl.sv
// rtl/upscale3x_ctrl.sv - 3x nearest-neighbour upscaler: buffers one input line, replays it as 3 output lines of 3x pixels
module upscale3x_ctrl #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 64,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    cfg_width,
  input  logic [9:0]       cfg_height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sol,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             done
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_w, r_wr_col, r_rd_col;
  logic [9:0]        r_h, r_row;
  logic [1:0]        r_col_rep, r_row_rep;
  logic [PIX_W-1:0]  r_buf [MAX_W];

  logic              w_accept, w_last_wr, w_col_end, w_line_end, w_row_wrap, w_last_row;
  logic [CW-1:0]     w_w_lim;

  assign w_accept   = start && (cfg_width != '0) && (cfg_height != '0);
  assign w_w_lim    = (cfg_width > CW'(MAX_W)) ? CW'(MAX_W) : cfg_width;
  assign w_last_wr  = (r_wr_col == r_w - CW'(1));
  assign w_col_end  = (r_rd_col == r_w - CW'(1));
  assign w_line_end = w_col_end && (r_col_rep == 2'd2);
  assign w_row_wrap = (r_row_rep == 2'd2);
  assign w_last_row = (r_row == r_h - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && w_last_wr) w_next = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_line_end && w_row_wrap) w_next = w_last_row ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Outputs read as idle for the whole reset cycle, even before the edge lands.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  assign out_data = r_buf[r_rd_col[AW-1:0]];
  assign out_sol  = out_valid && (r_rd_col == '0) && (r_col_rep == 2'd0);
  assign out_eol  = out_valid && w_line_end;
  assign out_eof  = out_eol && w_row_wrap && w_last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w       <= '0;
      r_h       <= '0;
      r_wr_col  <= '0;
      r_rd_col  <= '0;
      r_col_rep <= '0;
      r_row_rep <= '0;
      r_row     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_w       <= w_w_lim;
            r_h       <= cfg_height;
            r_wr_col  <= '0;
            r_rd_col  <= '0;
            r_col_rep <= '0;
            r_row_rep <= '0;
            r_row     <= '0;
          end
        end
        S_FILL: begin
          if (in_valid) r_wr_col <= w_last_wr ? '0 : r_wr_col + CW'(1);
        end
        S_EMIT: begin
          if (out_ready) begin
            r_col_rep <= (r_col_rep == 2'd2) ? 2'd0 : r_col_rep + 2'd1;
            if (r_col_rep == 2'd2) r_rd_col <= w_col_end ? '0 : r_rd_col + CW'(1);
            if (w_line_end) begin
              r_row_rep <= w_row_wrap ? 2'd0 : r_row_rep + 2'd1;
              if (w_row_wrap && !w_last_row) r_row <= r_row + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) r_buf[r_wr_col[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_upscale3x_ctrl.sv
// tb/tb_upscale3x_ctrl.sv - directed bench for upscale3x_ctrl with a frame-level reference model
module tb_upscale3x_ctrl;

  localparam int PIX_W = 8;
  localparam int MAX_W = 64;
  localparam int CW    = 7;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]    cfg_width;
  logic [9:0]       cfg_height;
  logic [PIX_W-1:0] in_data, out_data;
  logic             out_sol, out_eol, out_eof, busy, done;

  upscale3x_ctrl #(.PIX_W(PIX_W), .MAX_W(MAX_W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PIX_W-1:0] d;
    logic sol;
    logic eol;
    logic eof;
  } px_t;

  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0;
  px_t exp_q[$];
  px_t log_q[$];
  logic [PIX_W-1:0] in_pix[$];
  int  n_in, n_out, n_done, line_cnt, cur_w, last_hs_cyc, done_cyc;
  bit  stalled_prev, exp_emit;
  px_t held;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output-side monitor: every sampled cycle is checked against the model queue.
  always @(negedge clk) begin
    px_t a, e;
    a = '{d: out_data, sol: out_sol, eol: out_eol, eof: out_eof};
    check("no_fill_emit_overlap", {63'd0, out_valid & in_ready}, 64'd0);
    if (stalled_prev) check("stall_hold", {out_valid, a}, {1'b1, held});
    if (exp_emit) begin
      check("emit_after_fill", {63'd0, out_valid}, 64'd1);
      exp_emit = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_output", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("out_pixel", a, e);
      end
      log_q.push_back(a);
      last_hs_cyc = cyc;
      n_out++;
    end
    stalled_prev = out_valid && !out_ready;
    held = a;
    if (in_valid && in_ready) begin
      n_in++;
      line_cnt++;
      if (line_cnt == cur_w) begin
        line_cnt = 0;
        exp_emit = 1'b1;
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    log_q.delete();
    n_in = 0; n_out = 0; n_done = 0; line_cnt = 0;
    stalled_prev = 1'b0; exp_emit = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    check(nm, {in_ready, out_valid, busy, done, out_sol, out_eol, out_eof}, 64'd0);
  endtask

  task automatic run_frame(input int w, input int h, input bit gaps, input bit stalls,
                           input bit poke, input int rst_at);
    int  we, total, k;
    bit  hs_in, fin;
    we = (w > MAX_W) ? MAX_W : w;
    total = we * h;
    k = 0;
    fin = 1'b0;
    clear_mon();
    cur_w = we;
    for (int r = 0; r < h; r++)
      for (int rr = 0; rr < 3; rr++)
        for (int c = 0; c < we; c++)
          for (int cr = 0; cr < 3; cr++)
            exp_q.push_back('{d: in_pix[r*we+c], sol: (c == 0 && cr == 0),
                              eol: (c == we-1 && cr == 2),
                              eof: (c == we-1 && cr == 2 && rr == 2 && r == h-1)});
    start = 1'b1; cfg_width = w[CW-1:0]; cfg_height = h[9:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 30000 && !fin; t++) begin
      if (rst_at > 0 && n_out == rst_at - 1 && out_valid) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1 check_idle_outputs("during_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("after_rst");
        clear_mon();
        fin = 1'b1;
      end else begin
        in_valid  = (k < total) && (!gaps || $urandom_range(0, 2) != 0);
        in_data   = (k < total) ? in_pix[k] : '0;
        out_ready = !stalls || $urandom_range(0, 3) != 0;
        start     = poke && busy && !done && (t % 13 == 4);
        if (start) begin cfg_width = 1; cfg_height = 1; end
        @(negedge clk);
        hs_in = in_valid && in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        if (hs_in) k++;
        if (n_done != 0) fin = 1'b1;
      end
    end
    if (!fin) check("frame_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (rst_at == 0) begin
      check("model_drained", exp_q.size(), 64'd0);
      check("inputs_taken", n_in, total);
      check("outputs_made", n_out, 9 * total);
      check("done_pulses", n_done, 64'd1);
      check("idle_after_frame", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic zero_start(input int w, input int h);
    clear_mon();
    start = 1'b1; cfg_width = w[CW-1:0]; cfg_height = h[9:0];
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      check("zero_cfg_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
    end
    check("zero_cfg_done", n_done, 64'd0);
  endtask

  initial begin
    logic [63:0] sv, ev, fv;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_width = '0; cfg_height = '0; in_data = '0;
    clear_mon();
    cur_w = 1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_release");

    // 2x2 frame with hand-derived flag positions
    in_pix = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_frame(2, 2, 0, 0, 0, 0);
    check("log_len_2x2", log_q.size(), 64'd36);
    if (log_q.size() == 36) begin
      sv = '0; ev = '0; fv = '0;
      for (int i = 0; i < 36; i++) begin
        sv[i] = log_q[i].sol; ev[i] = log_q[i].eol; fv[i] = log_q[i].eof;
      end
      check("sol_positions", sv, 64'h041041041);
      check("eol_positions", ev, 64'h820820820);
      check("eof_positions", fv, 64'h800000000);
      check("px1_A",  log_q[0].d,  64'hA1);
      check("px4_B",  log_q[3].d,  64'hB2);
      check("px13_A", log_q[12].d, 64'hA1);
      check("px19_C", log_q[18].d, 64'hC3);
      check("px36_D", log_q[35].d, 64'hD4);
    end
    check("done_latency", done_cyc, last_hs_cyc + 1);

    // 3x2 under random backpressure
    in_pix = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    run_frame(3, 2, 0, 1, 0, 0);

    // start pokes while busy must be ignored
    in_pix = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_frame(3, 3, 0, 0, 1, 0);

    // input gaps plus output stalls
    in_pix = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87};
    run_frame(4, 2, 1, 1, 0, 0);

    zero_start(0, 3);
    zero_start(2, 0);

    // width clamp: 69 requested, 64 used
    in_pix.delete();
    for (int i = 0; i < MAX_W; i++) in_pix.push_back(PIX_W'(i * 7 + 3));
    run_frame(MAX_W + 5, 1, 0, 0, 0, 0);
    if (log_q.size() >= 192) begin
      check("clamp_eol_at_192", {log_q[191].eol, log_q[190].eol}, 64'b10);
      check("clamp_sol_at_193", {63'd0, log_q[192].sol}, 64'd1);
    end else check("clamp_log_len", log_q.size(), 64'd576);

    // reset on the 10th output of a 4x4 frame, then a clean 1x1 frame
    in_pix.delete();
    for (int i = 0; i < 16; i++) in_pix.push_back(PIX_W'(8'h40 + i));
    run_frame(4, 4, 0, 0, 0, 10);
    check_idle_outputs("idle_after_mid_rst");
    in_pix = '{8'h5A};
    run_frame(1, 1, 0, 0, 0, 0);
    if (log_q.size() == 9) begin
      fv = '0;
      for (int i = 0; i < 9; i++) fv[i] = log_q[i].eof;
      check("1x1_eof_only_9th", fv, 64'h100);
      check("1x1_pixel", log_q[4].d, 64'h5A);
    end else check("1x1_log_len", log_q.size(), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/upscale3x_ctrl.md
UPSCALE3X_CTRL -- requirements
Module: upscale3x_ctrl

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter MAX_W, default 64: maximum input line width in pixels, which is also the line buffer depth.
REQ-003 Parameter CW, default 7: width of the column config and counters; 2^CW > MAX_W.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 start  input  1  frame start request; sampled only in IDLE.
REQ-007 cfg_width  input  CW  input pixels per line; latched on an accepted start.
REQ-008 cfg_height  input  10  input lines per frame; latched on an accepted start.
REQ-009 in_valid  input  1  input pixel valid.
REQ-010 in_ready  output  1  controller accepts an input pixel.
REQ-011 in_data  input  PIX_W  input pixel.
REQ-012 out_valid  output  1  output pixel valid.
REQ-013 out_ready  input  1  downstream accepts an output pixel.
REQ-014 out_data  output  PIX_W  upscaled output pixel.
REQ-015 out_sol / out_eol / out_eof  output  1 each  start-of-line, end-of-line and end-of-frame flags, qualified by out_valid.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-018 The FSM states SHALL be IDLE, FILL, EMIT and DONE.
REQ-019 IDLE -> FILL SHALL occur when start=1, cfg_width!=0 and cfg_height!=0; the latch values are W=min(cfg_width,MAX_W) and H=cfg_height, and wr_col, rd_col, col_rep, row_rep and row are all cleared to 0.
REQ-020 A start with zero width or zero height SHALL be ignored: the block stays in IDLE and done is not asserted.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 In FILL: in_ready=1; on each handshake in_data is written to buf[wr_col] and wr_col increments; the handshake at wr_col=W-1 SHALL move the FSM to EMIT with wr_col cleared.
REQ-023 in_ready SHALL be 0 in all states other than FILL.
REQ-024 In EMIT, out_valid SHALL be 1 and out_data SHALL equal buf[rd_col].
REQ-025 col_rep and row_rep SHALL be mod-3 counters (0,1,2,0) that advance only on an output handshake.
REQ-026 Each output handshake SHALL advance col_rep; when col_rep wraps 2->0, rd_col increments.
REQ-027 The handshake at rd_col=W-1 with col_rep=2 ends the output line: rd_col is cleared and row_rep advances.
REQ-028 If row_rep wraps at a line end and row<H-1: row increments and the FSM goes to FILL.
REQ-029 If row_rep wraps at a line end and row=H-1: the FSM goes to DONE.
REQ-030 If row_rep does not wrap at a line end, the FSM stays in EMIT and replays the same buffered line.
REQ-031 Flag definitions: out_sol = (rd_col=0 and col_rep=0); out_eol = (rd_col=W-1 and col_rep=2); out_eof = out_eol and row_rep=2 and row=H-1.
REQ-032 While out_valid=1 and out_ready=0, out_data, all flags and all counters SHALL hold stable.
REQ-033 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-034 Throughput: one output pixel per cycle under continuous out_ready; one input pixel per cycle under continuous in_valid.
REQ-035 No output is produced during FILL (no fill/emit overlap).
REQ-036 Totals per frame: W*H input pixels accepted and 9*W*H output pixels produced.

Reset
REQ-037 rst=1 SHALL force IDLE and clear all counters and latched config on the same clock edge, including mid-FILL and mid-EMIT.
REQ-038 Output values during and after reset: in_ready=0, out_valid=0, busy=0, done=0, all flags 0.
REQ-039 Buffer contents SHALL NOT be reset; they are don't-care until rewritten.
REQ-040 The first start accepted after reset SHALL behave exactly as the first frame after power-up.

Verification
REQ-041 2x2 frame, pixels A,B,C,D, out_ready=1 -> 36 outputs: AAABBB three times, then CCCDDD three times; out_sol on outputs 1,7,13,19,25,31; out_eol on 6,12,18,24,30,36; out_eof only on 36; done pulses 1 cycle after the last handshake.
REQ-042 Random out_ready backpressure on a 3x2 frame -> output sequence identical to the no-stall case, out_data stable while stalled, exactly 54 handshakes.
REQ-043 start pulsed during FILL and EMIT -> ignored; frame count and output sequence unchanged.
REQ-044 rst asserted at the 10th output of a 4x4 frame -> next cycle IDLE, out_valid=0, busy=0; a new 1x1 frame then yields 9 identical pixels with out_eof on the 9th.
REQ-045 start with cfg_width=0 or cfg_height=0 -> busy stays 0, no done pulse; cfg_width=MAX_W+5 -> line length clamped to MAX_W (3*MAX_W outputs per output line).
REQ-046 in_valid gaps during FILL -> only handshaked pixels are written; EMIT starts on the cycle after the W-th accepted pixel.
